// File: rtl/motion_pkg.sv
// rtl/motion_pkg.sv - shared state encodings, widths and defaults for the motion alarm path
package motion_pkg;

  localparam int unsigned DEF_CONFIRM_FRAMES  = 3;
  localparam int unsigned DEF_HOLD_CYCLES     = 25_000_000;
  localparam int unsigned DEF_COOLDOWN_CYCLES = 100_000_000;

  localparam int unsigned EVENT_CNT_W = 8;
  localparam int unsigned RUN_W       = 4;
  localparam int unsigned HOLD_W      = 25;
  localparam int unsigned COOL_W      = 27;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_COOLDOWN = 2'd2
  } alarm_state_e;

  // Consecutive-frame count that sticks at the confirmation threshold.
  function automatic logic [RUN_W-1:0] sat_inc_run(input logic [RUN_W-1:0] v,
                                                   input logic [RUN_W-1:0] lim);
    return (v >= lim) ? lim : v + 1'b1;
  endfunction

endpackage

// File: rtl/vsync_edge_sync.sv
// rtl/vsync_edge_sync.sv - 2-FF synchronizer with registered rising-edge pulse
module vsync_edge_sync (
  input  logic clk,
  input  logic clr,
  input  logic async_in,
  output logic pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic pulse_q, pulse_d;

  always_comb begin
    sync1_d = async_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    pulse_d = sync2_q & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/motion_alarm_ctrl.sv
// rtl/motion_alarm_ctrl.sv - frame-confirmed motion alarm with LED hold, snapshot request and cooldown
module motion_alarm_ctrl
  import motion_pkg::*;
#(
  parameter int unsigned CONFIRM_FRAMES  = DEF_CONFIRM_FRAMES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   frame_start,
  input  logic                   motion_detected,
  input  logic                   arm,
  input  logic                   tx_done,
  output logic                   tx_start,
  output logic                   motion_led,
  output logic [1:0]             alarm_state,
  output logic [EVENT_CNT_W-1:0] event_count
);

  localparam logic [RUN_W-1:0]  RUN_MAX = RUN_W'(CONFIRM_FRAMES);
  localparam logic [HOLD_W-1:0] HOLD_LD = HOLD_W'(HOLD_CYCLES);
  localparam logic [COOL_W-1:0] COOL_LD = COOL_W'(COOLDOWN_CYCLES);

  logic frame_tick;

  alarm_state_e          state_q, state_d;
  logic                  hit_q, hit_d;
  logic [RUN_W-1:0]      run_q, run_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic                  led_q, led_d;
  logic [COOL_W-1:0]     cool_q, cool_d;
  logic                  tx_start_q, tx_start_d;
  logic [EVENT_CNT_W-1:0] event_q, event_d;

  logic                  closing;
  logic [RUN_W-1:0]      run_step;

  vsync_edge_sync u_vsync (
    .clk      (clk),
    .clr      (clr),
    .async_in (frame_start),
    .pulse    (frame_tick)
  );

  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    cool_d     = cool_q;
    tx_start_d = 1'b0;
    event_d    = event_q;

    // Motion seen in the tick cycle itself belongs to the frame being closed.
    closing  = hit_q | motion_detected;
    hit_d    = frame_tick ? 1'b0 : closing;
    run_step = closing ? sat_inc_run(run_q, RUN_MAX) : '0;

    hold_d = hold_q;
    if (motion_detected) begin
      hold_d = HOLD_LD;
    end else if (hold_q != '0) begin
      hold_d = hold_q - 1'b1;
    end
    led_d = motion_detected | (hold_q != '0);

    case (state_q)
      ST_IDLE: begin
        if (!arm) begin
          run_d = '0;
        end else if (frame_tick) begin
          run_d = run_step;
          if (run_step == RUN_MAX) begin
            state_d    = ST_SEND;
            tx_start_d = 1'b1;
            if (event_q != '1) begin
              event_d = event_q + 1'b1;
            end
          end
        end
      end
      ST_SEND: begin
        run_d = '0;
        if (tx_done) begin
          state_d = ST_COOLDOWN;
          cool_d  = COOL_LD;
        end else if (!arm) begin
          state_d = ST_IDLE;
        end
      end
      ST_COOLDOWN: begin
        // A tick landing on the expiry cycle is dropped: run stays at zero here.
        run_d = '0;
        if (cool_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cool_d = cool_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        run_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= ST_IDLE;
      hit_q      <= 1'b0;
      run_q      <= '0;
      hold_q     <= '0;
      led_q      <= 1'b0;
      cool_q     <= '0;
      tx_start_q <= 1'b0;
      event_q    <= '0;
    end else begin
      state_q    <= state_d;
      hit_q      <= hit_d;
      run_q      <= run_d;
      hold_q     <= hold_d;
      led_q      <= led_d;
      cool_q     <= cool_d;
      tx_start_q <= tx_start_d;
      event_q    <= event_d;
    end
  end

  assign tx_start    = tx_start_q;
  assign motion_led  = led_q;
  assign alarm_state = state_q;
  assign event_count = event_q;

endmodule
